// File: rtl/prog_sequencer.sv
// Boot/run sequencer for the processor core: fills the instruction memory from a
// word stream, holds the core in reset while loading, then supervises execution.
module prog_sequencer #(
    parameter  int BITNESS = 64,
    parameter  int DEPTH   = 256,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [15:0]        ld_data,
    input  logic               ld_last,
    input  logic [31:0]        run_budget,
    input  logic [BITNESS-1:0] pc,
    output logic [15:0]        instruction,
    output logic               core_rst_n,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic               timeout,
    output logic               fault,
    output logic [AW:0]        load_count,
    output logic [31:0]        cycle_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [AW:0]        load_count_q, load_count_d;
    logic [31:0]        cycle_count_q, cycle_count_d;
    logic [31:0]        budget_q, budget_d;
    logic [BITNESS-1:0] pc_q, pc_q_d;
    logic               pc_q_vld_q, pc_q_vld_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic               fault_q, fault_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               ld_ready_q, ld_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [15:0]        imem [DEPTH];
    logic               wr_en;
    logic               pc_in_range;
    logic [32:0]        cycle_next;

    assign pc_in_range = (pc >> AW) == {BITNESS{1'b0}};
    assign cycle_next  = {1'b0, cycle_count_q} + 33'd1;
    assign instruction = pc_in_range ? imem[pc[AW-1:0]] : 16'h0000;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        load_count_d  = load_count_q;
        cycle_count_d = cycle_count_q;
        budget_d      = budget_q;
        pc_q_d        = pc_q;
        pc_q_vld_d    = pc_q_vld_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        fault_d       = fault_q;
        wr_en         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    load_count_d  = '0;
                    cycle_count_d = '0;
                    pc_q_vld_d    = 1'b0;
                    halted_d      = 1'b0;
                    timeout_d     = 1'b0;
                    fault_d       = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ld_valid) begin
                    wr_en        = 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (ld_last || load_count_q == LAST_IDX) begin
                        state_d  = S_RUN;
                        budget_d = run_budget;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_next[31:0];
                    pc_q_d        = pc;
                    pc_q_vld_d    = 1'b1;
                    // Priority order when several causes coincide: fault, halt, timeout.
                    if (!pc_in_range) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (pc_q_vld_q && pc == pc_q) begin
                        halted_d = 1'b1;
                        state_d  = S_DONE;
                    end else if (budget_q != '0 && cycle_next == {1'b0, budget_q}) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_n_d = (state_d == S_RUN);
        ld_ready_d   = (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            load_count_q  <= '0;
            cycle_count_q <= '0;
            budget_q      <= '0;
            pc_q          <= '0;
            pc_q_vld_q    <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            fault_q       <= 1'b0;
            core_rst_n_q  <= 1'b0;
            ld_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            cycle_count_q <= cycle_count_d;
            budget_q      <= budget_d;
            pc_q          <= pc_q_d;
            pc_q_vld_q    <= pc_q_vld_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
            fault_q       <= fault_d;
            core_rst_n_q  <= core_rst_n_d;
            ld_ready_q    <= ld_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // NOTE: the memory has no reset; it keeps its contents across reset and aborted loads.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            imem[load_count_q[AW-1:0]] <= ld_data;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign core_rst_n  = core_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign fault       = fault_q;
    assign load_count  = load_count_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer (DEPTH=16): halt, timeout,
// depth-limited load, fault/timeout priority, abort with partial reload, mid-load reset.
module tb_prog_sequencer;

    localparam int BITNESS = 64;
    localparam int DEPTH   = 16;
    localparam int AW      = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic               ld_valid;
    logic               ld_ready;
    logic [15:0]        ld_data;
    logic               ld_last;
    logic [31:0]        run_budget;
    logic [BITNESS-1:0] pc;
    logic [15:0]        instruction;
    logic               core_rst_n;
    logic               busy;
    logic               done;
    logic               halted;
    logic               timeout;
    logic               fault;
    logic [AW:0]        load_count;
    logic [31:0]        cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    prog_sequencer #(.BITNESS(BITNESS), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .run_budget  (run_budget),
        .pc          (pc),
        .instruction (instruction),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .timeout     (timeout),
        .fault       (fault),
        .load_count  (load_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_imem(input string tag, input logic [BITNESS-1:0] addr, input logic [15:0] exp);
        pc = addr;
        #1;
        check(tag, 64'(instruction), 64'(exp));
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
        check({tag, "_ld_ready"},   64'(ld_ready),   64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_flags"},      64'({halted, timeout, fault}), 64'd0);
        check({tag, "_load_count"}, 64'(load_count), 64'd0);
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    endtask

    initial begin
        int n_acc;
        int first_drop;

        rst = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0;
        ld_data = '0; ld_last = 1'b0; run_budget = '0; pc = '0;
        tick();
        tick();
        check_idle_reset("reset");
        rst = 1'b1;

        // Halt: words 0..3, word 3 is a jump-to-self.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ld_ready", 64'(ld_ready), 64'd1);
        load_word(16'hA000, 1'b0);
        load_word(16'hA001, 1'b0);
        check("t1_core_held", 64'(core_rst_n), 64'd0);
        load_word(16'hA002, 1'b0);
        load_word(16'h0003, 1'b1);
        check("t1_run_core_rst_n", 64'(core_rst_n), 64'd1);
        check("t1_run_ld_ready", 64'(ld_ready), 64'd0);
        check("t1_load_count", 64'(load_count), 64'd4);
        read_imem("t1_instr0", 0, 16'hA000);
        tick();
        pc = 1;
        tick();
        pc = 2;
        tick();
        read_imem("t1_instr3", 3, 16'h0003);
        tick();
        pc = 3;
        check("t1_not_done_yet", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_flags", 64'({halted, timeout, fault}), 64'b100);
        check("t1_core_rst_n", 64'(core_rst_n), 64'd0);
        check("t1_cycle_count", 64'(cycle_count), 64'd5);
        check("t1_busy", 64'(busy), 64'd0);

        // Timeout: budget 10, pc never repeats.
        run_budget = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_flags_cleared", 64'({halted, timeout, fault}), 64'd0);
        check("t2_counts_cleared", 64'({load_count, cycle_count}), 64'd0);
        load_word(16'h1234, 1'b1);
        for (int i = 0; i < 10; i++) begin
            pc = 64'(i);
            check("t2_core_running", 64'(core_rst_n), 64'd1);
            tick();
        end
        check("t2_done", 64'(done), 64'd1);
        check("t2_flags", 64'({halted, timeout, fault}), 64'b010);
        check("t2_cycle_count", 64'(cycle_count), 64'd10);
        check("t2_core_rst_n", 64'(core_rst_n), 64'd0);

        // Depth limit: 20 words offered, no ld_last.
        run_budget = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_acc = 0;
        first_drop = -1;
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1;
            ld_data  = 16'hB000 + 16'(i);
            pc       = 64'(i % 16);
            if (ld_ready) n_acc++;
            else if (first_drop < 0) first_drop = i;
            tick();
        end
        ld_valid = 1'b0;
        check("t3_accepted", 64'(n_acc), 64'd16);
        check("t3_ready_drop", 64'(first_drop), 64'd16);
        check("t3_load_count", 64'(load_count), 64'd16);
        check("t3_in_run", 64'({core_rst_n, busy, ld_ready}), 64'b110);
        check("t3_cycle_count", 64'(cycle_count), 64'd4);
        read_imem("t3_word15", 15, 16'hB00F);

        // Abort mid-RUN with start also high.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t5_idle", 64'({busy, done, core_rst_n, ld_ready}), 64'd0);
        check("t5_count_hold", 64'(load_count), 64'd16);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart_clear", 64'(load_count), 64'd0);

        // Partial reload (word 0 only), budget 3 expires on the cycle pc leaves range.
        run_budget = 32'd3;
        load_word(16'hC000, 1'b1);
        read_imem("t5_word1", 1, 16'hB001);
        tick();
        read_imem("t5_word2", 2, 16'hB002);
        tick();
        read_imem("t4_oob", DEPTH, 16'h0000);
        tick();
        check("t4_done", 64'(done), 64'd1);
        check("t4_flags", 64'({halted, timeout, fault}), 64'b001);
        check("t4_cycle_count", 64'(cycle_count), 64'd3);
        read_imem("t4_oob_high", 64'h8000_0000_0000_0003, 16'h0000);
        read_imem("t5_word3", 3, 16'hB003);
        read_imem("t5_word0", 0, 16'hC000);

        // Reset mid-LOAD with a word pending: no write, outputs back to reset values.
        start = 1'b1;
        tick();
        start = 1'b0;
        load_word(16'hD000, 1'b0);
        check("t6_load_count", 64'(load_count), 64'd1);
        rst = 1'b0;
        ld_valid = 1'b1;
        ld_data = 16'hEEEE;
        tick();
        rst = 1'b1;
        ld_valid = 1'b0;
        check_idle_reset("t6");
        read_imem("t6_word1_kept", 1, 16'hB001);
        read_imem("t6_word0", 0, 16'hD000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
